pet_status_display: RTL and testbench
=====================================

Name: pet_status_display

Overview:
- Consumer of the pet-state FSM's four 3-bit need levels: NH (hunger), NS (health), NF (fun), NE (energy).
- Time-multiplexes the four levels onto a 4-digit common-anode 7-segment display.
- Blinks critical digits and raises an alarm while any level is critical.
- Runs a hysteretic mood state machine for the top-level LEDs.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays active; legal if >=2.
- BLINK_DIV, 12500000: clock cycles per blink half-period; legal if >=2.
- CRIT_LEVEL, 1: a level <= CRIT_LEVEL is critical.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- NH  input  3  hunger level 0..7.
- NS  input  3  health level 0..7.
- NF  input  3  fun level 0..7.
- NE  input  3  energy level 0..7.
- an  output  4  digit anodes, active-low; an[0]=NH, an[1]=NS, an[2]=NF, an[3]=NE.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- alarm  output  1  high while any snapshot level is critical.
- mood  output  2  00 DEAD, 01 SAD, 10 OK, 11 HAPPY.

Behaviour:
- Reset (rst=0, immediate, async): an=4'b1111, seg=7'b1111111, dp=1, alarm=0, mood=OK (10).
  - Internal: ref_cnt=0, digit index=0, snapshot={0,0,0,0}, blink_cnt=0, blink phase=0 (visible).
- Refresh:
  - ref_cnt counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
- Snapshot:
  - On the edge where the index wraps 3->0, all four inputs are latched together into the snapshot (no tearing).
  - Display, alarm and mood use only the snapshot. Inputs between snapshots are ignored.
- Display registers (1-cycle latency from the index):
  - an = one-hot-low for the index; seg = glyph of that digit's snapshot level.
  - Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - The first edge after reset release drives an=1110 with the glyph for 0.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; at terminal count the blink phase toggles.
  - When phase=1 and the active digit is critical, an=4'b1111 (blanked); seg still shows the glyph.
- dp: 0 when the active digit is critical, regardless of blink phase; else 1.
- alarm: registered on the snapshot edge as OR over the new values (level <= CRIT_LEVEL).
- mood FSM:
  - Evaluated on the snapshot edge from the new values. sum = NH+NS+NF+NE, 5-bit unsigned, 0..28.
  - Priority 1: all four levels 0 -> DEAD, from any state.
  - DEAD: sum>=8 -> OK; otherwise stay.
  - OK: sum>=22 -> HAPPY; sum<=10 -> SAD; otherwise stay.
  - HAPPY: sum<=10 -> SAD; sum<=18 -> OK; otherwise stay.
  - SAD: sum>=22 -> HAPPY; sum>=14 -> OK; otherwise stay.
  - Between snapshots, mood holds.
- Boundaries:
  - Input changes within one scan period (4*REFRESH_DIV cycles) appear only at the next wrap.
  - Level 7 shows glyph 7 with no overflow.
  - ref_cnt and blink_cnt run independently, so blink can toggle mid-digit; the blank applies from that cycle on.
  - Reset asserted mid-scan clears everything asynchronously; the scan restarts at digit 0.

Test Plan (REFRESH_DIV=4, BLINK_DIV=64; scan = 16 cycles):
1. Hold rst=0, inputs NH=5,NS=6,NF=7,NE=4 -> an=1111, seg=1111111, dp=1, alarm=0, mood=10. Release -> next edge an=1110, seg=1000000 (snapshot 0). After first 3->0 wrap, digit 0 seg=0010010 and NE digit (an=0111) seg=0011001. sum=22 from OK -> mood=11, alarm=0.
2. After test 1, change NS=3 mid-scan -> seg for an=1101 stays 0000010 until the next wrap, then 0110000. sum=19 from HAPPY -> mood stays 11.
3. Set NH=1,NS=2,NF=2,NE=3 -> at snapshot alarm=1, mood=01 (sum 8). NH digit has dp=0 always, and an=1111 during blink phase 1 (cycles 64..127 after reset release). Other digits never blank.
4. All inputs 0 -> mood=00. Then NH=NS=NF=NE=1 (sum 4) -> stays 00. Then all=2 (sum 8) -> mood=10.
5. From SAD, set sum=13 (3,3,3,4) -> stays 01. Set sum=14 (3,3,4,4) -> 10. From HAPPY, set sum=19 -> stays 11; set sum=18 -> 10.
6. Assert rst=0 mid-digit-2 -> outputs return to reset values within the same cycle, mood=10. After release the scan restarts at an=1110.

Source files
------------

// File: rtl/pet_status_display.sv
// Four-digit multiplexed status display for the pet need levels, with critical-digit
// blinking, an alarm flag and a hysteretic mood state machine driven from a per-scan snapshot.
module pet_status_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int CRIT_LEVEL  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] NH,
  input  logic [2:0] NS,
  input  logic [2:0] NF,
  input  logic [2:0] NE,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       alarm,
  output logic [1:0] mood
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_TC   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);
  localparam logic [2:0]    CRIT     = 3'(CRIT_LEVEL);

  typedef enum logic [1:0] {
    MOOD_DEAD  = 2'b00,
    MOOD_SAD   = 2'b01,
    MOOD_OK    = 2'b10,
    MOOD_HAPPY = 2'b11
  } mood_t;

  logic [RW-1:0]   r_ref_cnt;
  logic [1:0]      r_idx;
  logic [3:0][2:0] r_snap;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_phase;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            r_alarm;
  mood_t           r_mood;
  mood_t           w_mood_nxt;

  logic            w_ref_tc;
  logic            w_snap_evt;
  logic [2:0]      w_lvl;
  logic            w_crit;
  logic [4:0]      w_sum;
  logic            w_all_zero;
  logic            w_any_crit;
  logic [3:0]      w_an_nxt;

  function automatic logic [6:0] glyph(input logic [2:0] lvl);
    case (lvl)
      3'd0:    glyph = 7'b1000000;
      3'd1:    glyph = 7'b1111001;
      3'd2:    glyph = 7'b0100100;
      3'd3:    glyph = 7'b0110000;
      3'd4:    glyph = 7'b0011001;
      3'd5:    glyph = 7'b0010010;
      3'd6:    glyph = 7'b0000010;
      3'd7:    glyph = 7'b1111000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign w_ref_tc   = (r_ref_cnt == REF_TC);
  assign w_snap_evt = w_ref_tc && (r_idx == 2'd3);
  assign w_lvl      = r_snap[r_idx];
  assign w_crit     = (w_lvl <= CRIT);
  assign w_sum      = {2'b00, NH} + {2'b00, NS} + {2'b00, NF} + {2'b00, NE};
  assign w_all_zero = (NH == 3'd0) && (NS == 3'd0) && (NF == 3'd0) && (NE == 3'd0);
  assign w_any_crit = (NH <= CRIT) || (NS <= CRIT) || (NF <= CRIT) || (NE <= CRIT);

  // Anode pattern for the active digit; a critical digit is blanked in blink phase 1
  always_comb begin
    w_an_nxt = ~(4'b0001 << r_idx);
    if (r_phase && w_crit) begin
      w_an_nxt = 4'b1111;
    end else begin
      w_an_nxt = ~(4'b0001 << r_idx);
    end
  end

  // Mood transitions, evaluated only from the freshly latched levels
  always_comb begin
    w_mood_nxt = r_mood;
    if (!w_snap_evt) begin
      w_mood_nxt = r_mood;
    end else if (w_all_zero) begin
      w_mood_nxt = MOOD_DEAD;
    end else begin
      case (r_mood)
        MOOD_DEAD: begin
          if (w_sum >= 5'd8) w_mood_nxt = MOOD_OK;
          else               w_mood_nxt = MOOD_DEAD;
        end
        MOOD_OK: begin
          if (w_sum >= 5'd22)      w_mood_nxt = MOOD_HAPPY;
          else if (w_sum <= 5'd10) w_mood_nxt = MOOD_SAD;
          else                     w_mood_nxt = MOOD_OK;
        end
        MOOD_HAPPY: begin
          if (w_sum <= 5'd10)      w_mood_nxt = MOOD_SAD;
          else if (w_sum <= 5'd18) w_mood_nxt = MOOD_OK;
          else                     w_mood_nxt = MOOD_HAPPY;
        end
        MOOD_SAD: begin
          if (w_sum >= 5'd22)      w_mood_nxt = MOOD_HAPPY;
          else if (w_sum >= 5'd14) w_mood_nxt = MOOD_OK;
          else                     w_mood_nxt = MOOD_SAD;
        end
        default: w_mood_nxt = MOOD_OK;
      endcase
    end
  end

  // Mood state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mood <= MOOD_OK;
    else      r_mood <= w_mood_nxt;
  end

  // Refresh counter, digit index, snapshot and alarm
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ref_cnt <= '0;
      r_idx     <= 2'd0;
      r_snap    <= '0;
      r_alarm   <= 1'b0;
    end else begin
      r_ref_cnt <= w_ref_tc ? '0 : r_ref_cnt + 1'b1;
      if (w_ref_tc) r_idx <= r_idx + 2'd1;
      if (w_snap_evt) begin
        r_snap  <= {NE, NF, NS, NH};
        r_alarm <= w_any_crit;
      end
    end
  end

  // Blink timebase, free-running and independent of the digit scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_TC) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Display output registers, one cycle behind the digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= glyph(w_lvl);
      r_dp  <= ~w_crit;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign dp    = r_dp;
  assign alarm = r_alarm;
  assign mood  = r_mood;

endmodule

// File: tb/tb_pet_status_display.sv
// Directed bench for pet_status_display with small dividers (scan = 16 cycles, blink half = 64).
module tb_pet_status_display;

  logic       clk;
  logic       rst;
  logic [2:0] NH, NS, NF, NE;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       alarm;
  logic [1:0] mood;

  int n_vec;
  int n_err;

  pet_status_display #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (64),
    .CRIT_LEVEL (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .NH   (NH),
    .NS   (NS),
    .NF   (NF),
    .NE   (NE),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .alarm(alarm),
    .mood (mood)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    while (an !== target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) chk("wait_an_timeout", 32'(an), 32'(target));
  endtask

  task automatic set_lv(input logic [2:0] h, input logic [2:0] s,
                        input logic [2:0] f, input logic [2:0] e);
    NH = h; NS = s; NF = f; NE = e;
  endtask

  initial begin
    int blanks;
    int bad_dp;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    set_lv(3'd5, 3'd6, 3'd7, 3'd4);

    // 1: reset state, first digit, first snapshot
    tick(3);
    chk("rst_an",    32'(an),    32'(4'b1111));
    chk("rst_seg",   32'(seg),   32'(7'b1111111));
    chk("rst_dp",    32'(dp),    32'(1'b1));
    chk("rst_alarm", 32'(alarm), 32'(1'b0));
    chk("rst_mood",  32'(mood),  32'(2'b10));
    rst = 1'b1;
    tick(1);
    chk("first_an",  32'(an),  32'(4'b1110));
    chk("first_seg", 32'(seg), 32'(7'b1000000));
    tick(20);
    chk("t1_mood",  32'(mood),  32'(2'b11));
    chk("t1_alarm", 32'(alarm), 32'(1'b0));
    wait_an(4'b1110);
    chk("t1_nh_seg", 32'(seg), 32'(7'b0010010));
    chk("t1_nh_dp",  32'(dp),  32'(1'b1));
    wait_an(4'b0111);
    chk("t1_ne_seg", 32'(seg), 32'(7'b0011001));

    // 2: mid-scan change is held off until the next wrap
    wait_an(4'b1110);
    NS = 3'd3;
    wait_an(4'b1101);
    chk("t2_ns_old", 32'(seg), 32'(7'b0000010));
    tick(20);
    wait_an(4'b1101);
    chk("t2_ns_new", 32'(seg), 32'(7'b0110000));
    chk("t2_mood",   32'(mood), 32'(2'b11));

    // 3: critical hunger digit blinks and holds dp low
    set_lv(3'd1, 3'd2, 3'd2, 3'd3);
    tick(20);
    chk("t3_alarm", 32'(alarm), 32'(1'b1));
    chk("t3_mood",  32'(mood),  32'(2'b01));
    blanks = 0;
    bad_dp = 0;
    for (int i = 0; i < 256; i++) begin
      if (an == 4'b1111) blanks++;
      if ((an == 4'b1111 || an == 4'b1110) && dp !== 1'b0) bad_dp++;
      if ((an == 4'b1101 || an == 4'b1011 || an == 4'b0111) && dp !== 1'b1) bad_dp++;
      @(negedge clk);
    end
    chk("t3_blank_cnt", 32'(blanks), 32'd32);
    chk("t3_dp_bad",    32'(bad_dp), 32'd0);

    // 4: DEAD entry and exit
    set_lv(3'd0, 3'd0, 3'd0, 3'd0);
    tick(20);
    chk("t4_dead", 32'(mood), 32'(2'b00));
    set_lv(3'd1, 3'd1, 3'd1, 3'd1);
    tick(20);
    chk("t4_dead_hold", 32'(mood),  32'(2'b00));
    chk("t4_alarm",     32'(alarm), 32'(1'b1));
    set_lv(3'd2, 3'd2, 3'd2, 3'd2);
    tick(20);
    chk("t4_ok",       32'(mood),  32'(2'b10));
    chk("t4_alarm_off", 32'(alarm), 32'(1'b0));

    // 5: hysteresis thresholds around SAD and HAPPY
    set_lv(3'd1, 3'd2, 3'd2, 3'd2);
    tick(20);
    chk("t5_sad", 32'(mood), 32'(2'b01));
    set_lv(3'd3, 3'd3, 3'd3, 3'd4);
    tick(20);
    chk("t5_sad13", 32'(mood), 32'(2'b01));
    set_lv(3'd3, 3'd3, 3'd4, 3'd4);
    tick(20);
    chk("t5_ok14", 32'(mood), 32'(2'b10));
    set_lv(3'd7, 3'd7, 3'd7, 3'd7);
    tick(20);
    chk("t5_happy", 32'(mood), 32'(2'b11));
    wait_an(4'b1011);
    chk("t5_glyph7", 32'(seg), 32'(7'b1111000));
    set_lv(3'd5, 3'd5, 3'd5, 3'd4);
    tick(20);
    chk("t5_happy19", 32'(mood), 32'(2'b11));
    set_lv(3'd5, 3'd5, 3'd4, 3'd4);
    tick(20);
    chk("t5_ok18", 32'(mood), 32'(2'b10));

    // 6: asynchronous reset mid-digit-2
    set_lv(3'd7, 3'd7, 3'd7, 3'd7);
    tick(20);
    set_lv(3'd0, 3'd7, 3'd7, 3'd7);
    tick(20);
    chk("t6_pre_mood",  32'(mood),  32'(2'b11));
    chk("t6_pre_alarm", 32'(alarm), 32'(1'b1));
    wait_an(4'b1011);
    rst = 1'b0;
    #1;
    chk("t6_an",    32'(an),    32'(4'b1111));
    chk("t6_seg",   32'(seg),   32'(7'b1111111));
    chk("t6_dp",    32'(dp),    32'(1'b1));
    chk("t6_alarm", 32'(alarm), 32'(1'b0));
    chk("t6_mood",  32'(mood),  32'(2'b10));
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("t6_restart_an",  32'(an),  32'(4'b1110));
    chk("t6_restart_seg", 32'(seg), 32'(7'b1000000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
